mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Moore/Mealy control FSM that sequences a shared-ALU, single-memory multicycle MIPS datapath. Supported instructions: R-type, addi, lw, sw, beq, j.
Each cycle it drives the mux selects, write enables and ALUOp, and waits on a memory-ready handshake.
It also counts retired instructions and flags unsupported opcodes.

Parameters:
CNT_W, 16, width of retired-instruction counter
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes current access this cycle
PCWrite  output  1  unconditional PC load
Branch  output  1  PC load if ALU zero
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  1  regfile write data: 0 = ALUOut, 1 = MDR
RegDst  output  1  dest reg: 0 = rt, 1 = rd
RegWrite  output  1  regfile write enable
ALUSrcA  output  1  0 = PC, 1 = reg A
ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = decode funct
PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  output  1  unsupported opcode seen in DECODE
instr_done  output  1  one-cycle pulse on instruction retire
retired  output  CNT_W  retired-instruction count

Behaviour:
- State register only; all outputs are decoded from state, plus mem_ready gating where noted. Outputs not listed for a state are 0.
- Reset (async): state = IDLE, retired = 0. All outputs 0.
- IDLE: all outputs 0; -> FETCH on the first clock after rst deasserts.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite = mem_ready (Mealy-gated).
  - Stays in FETCH while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 0x00 -> EXEC
  - 0x08 -> ADDIEX
  - 0x23, 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - any other -> FETCH, with illegal_op=1 this cycle. Illegal instructions do not count and do not assert instr_done.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> MEMRD (0x23) or MEMWR (0x2B). opcode is re-read here and held stable by the datapath.
- MEMRD: MemRead=1, IorD=1; stays while mem_ready=0; -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH, retire.
- MEMWR: MemWrite=1, IorD=1; stays while mem_ready=0; -> FETCH, retiring on the exit cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH, retire.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH, retire.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1; -> FETCH, retire.
- JUMP: PCSrc=10, PCWrite=1; -> FETCH, retire.
- Retire:
  - instr_done=1 in the state's exit cycle, combinational.
  - retired increments on that clock edge; wraps 2^CNT_W-1 -> 0 with no flag.
- Latency with mem_ready tied 1, counted as cycles FETCH..last state inclusive:
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- MEM_WAIT_EN=0: mem_ready ignored; every memory state lasts exactly 1 cycle.
- Unreachable state encodings -> IDLE next cycle, outputs 0.
- Reset mid-instruction: immediate return to IDLE and counter clear. No partial write strobe survives: outputs go 0 asynchronously.
- MemRead and MemWrite are never both 1. RegWrite and PCWrite are never both 1.

Test Plan:
- Reset then mem_ready=1, opcode=0x00 -> IDLE 1 cycle, then FETCH, DECODE, EXEC, ALUWB. ALUWB has RegDst=1, RegWrite=1; instr_done in ALUWB; retired=1.
- lw (0x23) with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with MemRead=1, IorD=1. MEMWB then has MemtoReg=1, RegWrite=1; total 7 cycles.
- sw (0x2B), mem_ready=1 -> MEMWR 1 cycle with MemWrite=1, RegWrite=0; back to FETCH; 4 cycles total.
- Sequence beq (0x04) then j (0x02) -> BRANCH: ALUOp=01, PCSrc=01, Branch=1. JUMP: PCSrc=10, PCWrite=1. Each 3 cycles; retired +2.
- opcode=0x3F -> illegal_op=1 in DECODE, next FETCH; retired unchanged, no instr_done.
- Preload retired to 0xFFFF via 65535 addi instructions (CNT_W=16). Next retire -> 0x0000. Then assert rst during MEMWR -> outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences a shared-ALU, single-memory datapath for
// R-type, addi, lw, sw, beq and j, and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             Branch,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StBranch = 4'd11,
        StJump   = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             mem_rdy;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign retired = retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Outputs depend on state only, except the mem_ready-gated strobes and exits.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
                if (mem_rdy) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OpRtype:    state_d = StExec;
                    OpAddi:     state_d = StAddiEx;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_rdy) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expected controls, a negedge monitor compares.
// A second, 4-bit-counter instance shares the stimulus to exercise counter wrap cheaply.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
    logic        ALUSrcA, illegal_op, instr_done;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
    logic [15:0] retired;

    logic        n_PCWrite, n_Branch, n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_MemtoReg;
    logic        n_RegDst, n_RegWrite, n_ALUSrcA, n_illegal_op, n_instr_done;
    logic [1:0]  n_ALUSrcB, n_ALUOp, n_PCSrc;
    logic [3:0]  n_retired;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(16), .MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .illegal_op(illegal_op), .instr_done(instr_done), .retired(retired)
    );

    mips_multicycle_ctrl #(.CNT_W(4), .MEM_WAIT_EN(1'b1)) dut_n (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(n_PCWrite), .Branch(n_Branch), .IorD(n_IorD), .MemRead(n_MemRead),
        .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .MemtoReg(n_MemtoReg), .RegDst(n_RegDst),
        .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp),
        .PCSrc(n_PCSrc), .illegal_op(n_illegal_op), .instr_done(n_instr_done),
        .retired(n_retired)
    );

    // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
    //  ALUSrcB,ALUOp,PCSrc,illegal_op,instr_done}
    logic [17:0] act, act_n;
    assign act   = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                    RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op, instr_done};
    assign act_n = {n_PCWrite, n_Branch, n_IorD, n_MemRead, n_MemWrite, n_IRWrite,
                    n_MemtoReg, n_RegDst, n_RegWrite, n_ALUSrcA, n_ALUSrcB, n_ALUOp,
                    n_PCSrc, n_illegal_op, n_instr_done};

    typedef struct {
        logic [17:0] ctl;
        logic [15:0] ret;
        logic [3:0]  ret_n;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_ret;

    logic [17:0] E_IDLE, E_FETCH, E_FETCH_W, E_DEC, E_DEC_ILL, E_MEMADR, E_MEMRD, E_MEMWB;
    logic [17:0] E_MEMWR_W, E_MEMWR, E_EXEC, E_ALUWB, E_ADDIEX, E_ADDIWB, E_BRANCH, E_JUMP;

    function automatic logic [17:0] mk(input logic pcw, br, iord, mrd, mwr, irw, m2r, rdst,
                                       rw, asa, input logic [1:0] asb, aop, pcs,
                                       input logic ill, done);
        return {pcw, br, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, done};
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            n_cmp++;
            if (act !== e.ctl) begin
                n_bad++;
                $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
            end
            n_cmp++;
            if (act_n !== e.ctl) begin
                n_bad++;
                $display("FAIL %s ctl_n: got %b want %b", e.name, act_n, e.ctl);
            end
            n_cmp++;
            if (retired !== e.ret) begin
                n_bad++;
                $display("FAIL %s retired: got %h want %h", e.name, retired, e.ret);
            end
            n_cmp++;
            if (n_retired !== e.ret_n) begin
                n_bad++;
                $display("FAIL %s retired_n: got %h want %h", e.name, n_retired, e.ret_n);
            end
        end
    end

    task automatic expect_now(input logic [17:0] ctl, input string name);
        exp_t x;
        x.ctl   = ctl;
        x.ret   = exp_ret;
        x.ret_n = exp_ret[3:0];
        x.name  = name;
        q.push_back(x);
    endtask

    // One cycle: drive inputs, register expectation, advance past the edge.
    task automatic step(input logic [5:0] op, input logic mr, input logic [17:0] ctl,
                        input string name, input bit chk);
        opcode    = op;
        mem_ready = mr;
        if (chk) expect_now(ctl, name);
        @(posedge clk);
        if (ctl[0]) exp_ret = exp_ret + 16'd1;
        #1;
    endtask

    task automatic run_addi(input bit chk);
        step(6'h08, 1'b1, E_FETCH,  "addi_fetch",  chk);
        step(6'h08, 1'b1, E_DEC,    "addi_decode", chk);
        step(6'h08, 1'b1, E_ADDIEX, "addi_ex",     chk);
        step(6'h08, 1'b1, E_ADDIWB, "addi_wb",     chk);
    endtask

    initial begin
        E_IDLE    = '0;
        E_FETCH   = mk(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
        E_FETCH_W = mk(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
        E_DEC     = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
        E_DEC_ILL = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 1,0);
        E_MEMADR  = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
        E_MEMRD   = mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        E_MEMWB   = mk(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0,1);
        E_MEMWR_W = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        E_MEMWR   = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,1);
        E_EXEC    = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0);
        E_ALUWB   = mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0,1);
        E_ADDIEX  = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
        E_ADDIWB  = mk(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0,1);
        E_BRANCH  = mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0,1);
        E_JUMP    = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0,1);

        exp_ret   = '0;
        rst       = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(6'h00, 1'b1, E_IDLE, "reset_held", 1);
        rst = 1'b0;
        step(6'h00, 1'b1, E_IDLE, "idle_after_reset", 1);

        // R-type
        step(6'h00, 1'b1, E_FETCH, "r_fetch",  1);
        step(6'h00, 1'b1, E_DEC,   "r_decode", 1);
        step(6'h00, 1'b1, E_EXEC,  "r_exec",   1);
        step(6'h00, 1'b1, E_ALUWB, "r_aluwb",  1);

        // lw with two wait cycles in MEMRD
        step(6'h23, 1'b1, E_FETCH,  "lw_fetch",  1);
        step(6'h23, 1'b1, E_DEC,    "lw_decode", 1);
        step(6'h23, 1'b1, E_MEMADR, "lw_memadr", 1);
        step(6'h23, 1'b0, E_MEMRD,  "lw_memrd0", 1);
        step(6'h23, 1'b0, E_MEMRD,  "lw_memrd1", 1);
        step(6'h23, 1'b1, E_MEMRD,  "lw_memrd2", 1);
        step(6'h23, 1'b1, E_MEMWB,  "lw_memwb",  1);

        // sw, no waits
        step(6'h2B, 1'b1, E_FETCH,  "sw_fetch",  1);
        step(6'h2B, 1'b1, E_DEC,    "sw_decode", 1);
        step(6'h2B, 1'b1, E_MEMADR, "sw_memadr", 1);
        step(6'h2B, 1'b1, E_MEMWR,  "sw_memwr",  1);

        // beq with one fetch wait, then j
        step(6'h04, 1'b0, E_FETCH_W, "beq_fetch_wait", 1);
        step(6'h04, 1'b1, E_FETCH,   "beq_fetch",      1);
        step(6'h04, 1'b1, E_DEC,     "beq_decode",     1);
        step(6'h04, 1'b1, E_BRANCH,  "beq_branch",     1);
        step(6'h02, 1'b1, E_FETCH,   "j_fetch",        1);
        step(6'h02, 1'b1, E_DEC,     "j_decode",       1);
        step(6'h02, 1'b1, E_JUMP,    "j_jump",         1);

        // Illegal opcode: no retire
        step(6'h3F, 1'b1, E_FETCH,   "ill_fetch",  1);
        step(6'h3F, 1'b1, E_DEC_ILL, "ill_decode", 1);
        step(6'h00, 1'b1, E_FETCH,   "ill_refetch", 1);
        step(6'h00, 1'b1, E_DEC,     "r2_decode",  1);
        step(6'h00, 1'b1, E_EXEC,    "r2_exec",    1);
        step(6'h00, 1'b1, E_ALUWB,   "r2_aluwb",   1);

        // Drive the 4-bit counter to 15, then watch it wrap while the 16-bit one does not
        while (exp_ret[3:0] != 4'hF) run_addi(0);
        run_addi(1);

        // sw stalled in MEMWR, then asynchronous reset mid-write
        step(6'h2B, 1'b1, E_FETCH,   "wrap_fetch",   1);
        step(6'h2B, 1'b1, E_DEC,     "sw2_decode",   1);
        step(6'h2B, 1'b1, E_MEMADR,  "sw2_memadr",   1);
        step(6'h2B, 1'b0, E_MEMWR_W, "sw2_memwr_w",  1);
        #2;
        rst     = 1'b1;
        exp_ret = '0;
        #1;
        expect_now(E_IDLE, "async_reset_memwr");
        @(posedge clk);
        #1;
        step(6'h2B, 1'b1, E_IDLE, "reset_hold_idle", 1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
